// File: rtl/iopage_pkg.sv
// ----------------------------------------------------------------------------
// iopage_pkg
// Shared definitions for the I/O-page bus master: FSM state encoding, the
// I/O-page base address and the 9-bit upper-address match constant.
// Configuration macro used by the master: IOPAGE_ODD_TRAP_EN.
// ----------------------------------------------------------------------------
package iopage_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      DONE   = 2'd3
   } iop_state_t;

   localparam logic [21:0] IOPAGE_BASE  = 22'h3FE000;
   // cpu_addr[21:13] of every address inside the top 8 KB I/O page
   localparam logic [8:0]  IOPAGE_MATCH = 9'h1FF;

   function automatic logic in_iopage(input logic [21:0] a);
      return a[21:13] == IOPAGE_MATCH;
   endfunction

endpackage

// File: rtl/iopage_if.sv
// ----------------------------------------------------------------------------
// iopage_if
// Groups the CPU request/response handshake and the I/O-page device bus.
//   master : the bus master view (iopage_master)
//   slave  : the environment view (CPU + device mux / decoder)
// CPU side : cpu_req, cpu_wr, cpu_byte_op, cpu_addr, cpu_wdata  -> master
//            cpu_ready, cpu_rdata, cpu_nxm, cpu_odd              <- master
// Bus side : address, data_out, iopage_rd, iopage_wr,
//            iopage_byte_op                                      <- master
//            data_in, no_decode                                  -> master
// ----------------------------------------------------------------------------
interface iopage_if;
   logic        cpu_req;
   logic        cpu_wr;
   logic        cpu_byte_op;
   logic [21:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_ready;
   logic [15:0] cpu_rdata;
   logic        cpu_nxm;
   logic        cpu_odd;
   logic [21:0] address;
   logic [15:0] data_out;
   logic [15:0] data_in;
   logic        iopage_rd;
   logic        iopage_wr;
   logic        iopage_byte_op;
   logic        no_decode;

   modport master (
      input  cpu_req, cpu_wr, cpu_byte_op, cpu_addr, cpu_wdata, data_in, no_decode,
      output cpu_ready, cpu_rdata, cpu_nxm, cpu_odd,
             address, data_out, iopage_rd, iopage_wr, iopage_byte_op
   );

   modport slave (
      output cpu_req, cpu_wr, cpu_byte_op, cpu_addr, cpu_wdata, data_in, no_decode,
      input  cpu_ready, cpu_rdata, cpu_nxm, cpu_odd,
             address, data_out, iopage_rd, iopage_wr, iopage_byte_op
   );
endinterface

// File: rtl/iopage_strobe_timer.sv
// ----------------------------------------------------------------------------
// iopage_strobe_timer
// Strobe-length down counter. Loaded with CYCLES-1 while the master is in
// SETUP, counts down while enabled in STROBE, and flags the final strobe
// cycle when the count reaches zero.
// Ports: clk, reset (sync, active high), load, en, last.
// ----------------------------------------------------------------------------
module iopage_strobe_timer #(
   parameter int CYCLES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic en,
   output logic last
);

   logic [3:0] cnt;

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= 4'd0;
      else if (load)
         cnt <= 4'(CYCLES - 1);
      else if (en && cnt != 4'd0)
         cnt <= cnt - 4'd1;
   end

   assign last = (cnt == 4'd0);

endmodule

// File: rtl/iopage_master.sv
// ----------------------------------------------------------------------------
// iopage_master
// Turns one CPU request into one I/O-page bus cycle:
//   IDLE -> SETUP (address/byte qualifier out, strobes low)
//        -> STROBE (rd or wr held STROBE_CYCLES cycles)
//        -> DONE (one-cycle cpu_ready) -> IDLE
// Requests outside the I/O page go IDLE -> DONE with cpu_nxm set and no strobe.
// Ports: clk, reset (sync, active high), bus (iopage_if.master).
// Macro IOPAGE_ODD_TRAP_EN: when defined, word requests at odd addresses are
// trapped (cpu_odd, no strobe, priority over nxm); otherwise cpu_odd is 0
// and word addresses have bit 0 cleared.
// ----------------------------------------------------------------------------
module iopage_master
   import iopage_pkg::*;
#(
   parameter int STROBE_CYCLES = 2
) (
   input  logic     clk,
   input  logic     reset,
   iopage_if.master bus
);

   iop_state_t  state_q, state_d;
   logic        accept;
   logic        in_page;
   logic        odd_trap;
   logic        strobe_last;

   logic        wr_q;
   logic        byte_q;
   logic [21:0] addr_q;
   logic [15:0] dout_q;
   logic [15:0] rdata_q;
   logic        nxm_q;

   assign in_page = in_iopage(bus.cpu_addr);

`ifdef IOPAGE_ODD_TRAP_EN
   logic odd_q;

   assign odd_trap = ~bus.cpu_byte_op & bus.cpu_addr[0];

   always_ff @(posedge clk) begin
      if (reset)
         odd_q <= 1'b0;
      else if (accept)
         odd_q <= odd_trap;
   end

   assign bus.cpu_odd = odd_q;
`else
   assign odd_trap    = 1'b0;
   assign bus.cpu_odd = 1'b0;
`endif

   iopage_strobe_timer #(.CYCLES(STROBE_CYCLES)) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (state_q == SETUP),
      .en    (state_q == STROBE),
      .last  (strobe_last)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.cpu_req) begin
               accept = 1'b1;
               if (odd_trap || !in_page)
                  state_d = DONE;
               else
                  state_d = SETUP;
            end
         end
         SETUP:   state_d = STROBE;
         STROBE:  if (strobe_last) state_d = DONE;
         DONE:    state_d = IDLE;   // cpu_req still high here is not a new request
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q    <= 1'b0;
         byte_q  <= 1'b0;
         addr_q  <= '0;
         dout_q  <= '0;
         rdata_q <= '0;
         nxm_q   <= 1'b0;
      end else begin
         if (accept) begin
            nxm_q <= ~odd_trap & ~in_page;
            if (in_page && !odd_trap) begin
               wr_q   <= bus.cpu_wr;
               byte_q <= bus.cpu_byte_op;
               // word accesses are always even on the bus
               addr_q <= {bus.cpu_addr[21:1], bus.cpu_addr[0] & bus.cpu_byte_op};
               if (bus.cpu_wr)
                  dout_q <= bus.cpu_byte_op ? {2{bus.cpu_wdata[7:0]}} : bus.cpu_wdata;
            end
         end
         if (state_q == STROBE && strobe_last) begin
            nxm_q <= bus.no_decode;
            // an unclaimed read leaves the previous read data in place
            if (!wr_q && !bus.no_decode) begin
               if (!byte_q)
                  rdata_q <= bus.data_in;
               else if (addr_q[0])
                  rdata_q <= {8'h00, bus.data_in[15:8]};
               else
                  rdata_q <= {8'h00, bus.data_in[7:0]};
            end
         end
      end
   end

   assign bus.address        = addr_q;
   assign bus.data_out       = dout_q;
   assign bus.iopage_byte_op = byte_q & (state_q != IDLE);
   assign bus.iopage_rd      = (state_q == STROBE) & ~wr_q;
   assign bus.iopage_wr      = (state_q == STROBE) &  wr_q;
   assign bus.cpu_ready      = (state_q == DONE);
   assign bus.cpu_rdata      = rdata_q;
   assign bus.cpu_nxm        = nxm_q;

endmodule

// File: tb/tb_iopage_master.sv
// ----------------------------------------------------------------------------
// tb_iopage_master
// Directed bench for iopage_master at STROBE_CYCLES = 2. Inputs are driven
// and outputs sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_iopage_master;

   localparam int SC = 2;

   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_err = 0;
   int   n_both = 0;

   iopage_if bus();

   iopage_master #(.STROBE_CYCLES(SC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Issue one request (called #1 after an edge), run until cpu_ready or a
   // 12-edge budget, and report latency in edges plus what the bus showed.
   task automatic run_req(input logic wr, input logic bt, input logic [21:0] a,
                          input logic [15:0] wd, input logic [15:0] din, input logic nd,
                          output int lat, output int nrd, output int nwr,
                          output logic [21:0] sa, output logic [15:0] sdo, output logic sbo);
      bus.cpu_req     = 1'b1;
      bus.cpu_wr      = wr;
      bus.cpu_byte_op = bt;
      bus.cpu_addr    = a;
      bus.cpu_wdata   = wd;
      bus.data_in     = din;
      bus.no_decode   = nd;
      lat = -1; nrd = 0; nwr = 0; sa = '0; sdo = '0; sbo = 1'b0;
      for (int i = 1; i <= 12 && lat < 0; i++) begin
         @(posedge clk); #1;
         if (bus.iopage_rd) nrd++;
         if (bus.iopage_wr) nwr++;
         if (bus.iopage_rd && bus.iopage_wr) n_both++;
         if (bus.iopage_rd || bus.iopage_wr) begin
            sa  = bus.address;
            sdo = bus.data_out;
            sbo = bus.iopage_byte_op;
         end
         if (bus.cpu_ready) lat = i;
      end
      bus.cpu_req = 1'b0;
   endtask

   initial begin
      int lat, nrd, nwr, nrdy;
      logic [21:0] sa;
      logic [15:0] sdo;
      logic sbo;

      reset = 1'b1;
      bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_byte_op = 1'b0;
      bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.data_in = '0; bus.no_decode = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", bus.cpu_ready, 0);
      chk("rst_rd",    bus.iopage_rd, 0);
      chk("rst_wr",    bus.iopage_wr, 0);
      chk("rst_addr",  bus.address, 0);
      chk("rst_dout",  bus.data_out, 0);
      chk("rst_rdata", bus.cpu_rdata, 0);
      chk("rst_nxm",   bus.cpu_nxm, 0);
      chk("rst_odd",   bus.cpu_odd, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // word read, device returns 0080
      run_req(0, 0, 22'h3FFF70, 16'h0000, 16'h0080, 0, lat, nrd, nwr, sa, sdo, sbo);
      chk("wrd_lat",   lat, SC + 2);
      chk("wrd_nrd",   nrd, SC);
      chk("wrd_nwr",   nwr, 0);
      chk("wrd_addr",  sa, 22'h3FFF70);
      chk("wrd_bo",    sbo, 0);
      chk("wrd_rdata", bus.cpu_rdata, 16'h0080);
      chk("wrd_nxm",   bus.cpu_nxm, 0);
      @(posedge clk); #1;
      chk("wrd_rdy_pulse", bus.cpu_ready, 0);

      // byte write A5 at odd address
      run_req(1, 1, 22'h3FFF77, 16'h12A5, 16'h0000, 0, lat, nrd, nwr, sa, sdo, sbo);
      chk("bwr_lat",   lat, SC + 2);
      chk("bwr_nwr",   nwr, SC);
      chk("bwr_nrd",   nrd, 0);
      chk("bwr_dout",  sdo, 16'hA5A5);
      chk("bwr_bo",    sbo, 1);
      chk("bwr_addr",  sa, 22'h3FFF77);
      chk("bwr_rdata", bus.cpu_rdata, 16'h0080);
      @(posedge clk); #1;

      // unclaimed read: nxm, read data unchanged
      run_req(0, 0, 22'h3FFE00, 16'h0000, 16'hBEEF, 1, lat, nrd, nwr, sa, sdo, sbo);
      chk("nd_lat",   lat, SC + 2);
      chk("nd_nrd",   nrd, SC);
      chk("nd_nxm",   bus.cpu_nxm, 1);
      chk("nd_rdata", bus.cpu_rdata, 16'h0080);
      @(posedge clk); #1;

      // outside the I/O page: straight to DONE, no strobe
      run_req(0, 0, 22'h001000, 16'h0000, 16'h1111, 0, lat, nrd, nwr, sa, sdo, sbo);
      chk("oop_lat",   lat, 1);
      chk("oop_nrd",   nrd, 0);
      chk("oop_nwr",   nwr, 0);
      chk("oop_nxm",   bus.cpu_nxm, 1);
      chk("oop_rdata", bus.cpu_rdata, 16'h0080);
      @(posedge clk); #1;

      // byte reads pick the lane by address[0], zero-extended
      run_req(0, 1, 22'h3FFF71, 16'h0000, 16'hC33C, 0, lat, nrd, nwr, sa, sdo, sbo);
      chk("brd_hi_rdata", bus.cpu_rdata, 16'h00C3);
      chk("brd_hi_nxm",   bus.cpu_nxm, 0);
      @(posedge clk); #1;
      run_req(0, 1, 22'h3FFF70, 16'h0000, 16'hC33C, 0, lat, nrd, nwr, sa, sdo, sbo);
      chk("brd_lo_rdata", bus.cpu_rdata, 16'h003C);
      @(posedge clk); #1;

      // odd word address
      run_req(0, 0, 22'h3FFF71, 16'h0000, 16'h1234, 0, lat, nrd, nwr, sa, sdo, sbo);
`ifdef IOPAGE_ODD_TRAP_EN
      chk("odd_lat",   lat, 1);
      chk("odd_nrd",   nrd, 0);
      chk("odd_flag",  bus.cpu_odd, 1);
      chk("odd_nxm",   bus.cpu_nxm, 0);
      chk("odd_rdata", bus.cpu_rdata, 16'h003C);
      @(posedge clk); #1;
      run_req(0, 0, 22'h001001, 16'h0000, 16'h0000, 0, lat, nrd, nwr, sa, sdo, sbo);
      chk("oddprio_odd", bus.cpu_odd, 1);
      chk("oddprio_nxm", bus.cpu_nxm, 0);
`else
      chk("odd_lat",   lat, SC + 2);
      chk("odd_nrd",   nrd, SC);
      chk("odd_addr",  sa, 22'h3FFF70);
      chk("odd_flag",  bus.cpu_odd, 0);
      chk("odd_rdata", bus.cpu_rdata, 16'h1234);
`endif
      @(posedge clk); #1;

      // reset in the first STROBE cycle
      bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_byte_op = 1'b0;
      bus.cpu_addr = 22'h3FFF70; bus.data_in = 16'h7777; bus.no_decode = 1'b0;
      @(posedge clk); #1;
      chk("mid_setup_rd", bus.iopage_rd, 0);
      @(posedge clk); #1;
      chk("mid_strobe_rd", bus.iopage_rd, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_rd",    bus.iopage_rd, 0);
      chk("mid_rst_wr",    bus.iopage_wr, 0);
      chk("mid_rst_ready", bus.cpu_ready, 0);
      chk("mid_rst_addr",  bus.address, 0);
      chk("mid_rst_rdata", bus.cpu_rdata, 0);
      reset = 1'b0;
      bus.cpu_req = 1'b0;
      nrdy = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (bus.cpu_ready) nrdy++;
      end
      chk("mid_no_ready", nrdy, 0);

      run_req(1, 0, 22'h3FFF72, 16'h5A5A, 16'h0000, 0, lat, nrd, nwr, sa, sdo, sbo);
      chk("post_lat",  lat, SC + 2);
      chk("post_nwr",  nwr, SC);
      chk("post_dout", sdo, 16'h5A5A);
      chk("post_nxm",  bus.cpu_nxm, 0);
      @(posedge clk); #1;

      chk("rd_wr_never_both", n_both, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
